// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the decoder/execute stage and the M-extension sequencer.
interface muldiv_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, rs1, rs2, kill,
    input  busy, done, result
  );

  modport slave (
    input  start, op, rs1, rs2, kill,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-divide step per cycle,
// sign fix-up afterwards, divide-by-zero and signed overflow resolved at accept.
module muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic          clk,
  input logic          rst,
  muldiv_seq_if.slave  bus
);

  localparam logic [XLEN-1:0]  IntMin  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e r_state, w_state_next;

  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_mag_a, r_mag_b;
  logic              r_neg_q, r_neg_r;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;   // {partial product high, multiplier bits not yet consumed}
  logic [XLEN-1:0]   r_rem;   // divide partial remainder
  logic [XLEN-1:0]   r_quo;   // dividend bits shift out of the top, quotient bits shift in
  logic [XLEN-1:0]   r_result;

  logic              w_accept, w_div0, w_ovf, w_special;
  logic              w_signed_a, w_signed_b, w_sign_a, w_sign_b;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_special_result;
  logic [XLEN:0]     w_sum, w_shift;
  logic [2*XLEN-1:0] w_acc_next, w_prod_fix;
  logic              w_ge;
  logic [XLEN-1:0]   w_sub, w_quo_fix, w_rem_fix, w_fix_result;

  // Accept decode: operand signedness, magnitudes and special-case results.
  always_comb begin
    w_accept   = ((r_state == StIdle) || (r_state == StDone)) && bus.start && !bus.kill;
    w_signed_a = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] != 2'b11);
    w_signed_b = bus.op[2] ? ~bus.op[0] : ~bus.op[1];
    w_sign_a   = w_signed_a & bus.rs1[XLEN-1];
    w_sign_b   = w_signed_b & bus.rs2[XLEN-1];
    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    w_mag_a    = w_sign_a ? -bus.rs1 : bus.rs1;
    w_mag_b    = w_sign_b ? -bus.rs2 : bus.rs2;
    w_div0     = bus.op[2] && (bus.rs2 == '0);
    w_ovf      = bus.op[2] && !bus.op[0] && (bus.rs1 == IntMin) && (bus.rs2 == '1);
    w_special  = w_div0 || w_ovf;
    if (w_div0) begin
      w_special_result = bus.op[1] ? bus.rs1 : '1;
    end else begin
      w_special_result = bus.op[1] ? '0 : IntMin;
    end
  end

  // One iteration step for both loops plus the final sign correction and result select.
  always_comb begin
    w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
    w_acc_next = {w_sum, r_acc[XLEN-1:1]};
    w_shift    = {r_rem, r_quo[XLEN-1]};
    w_ge       = (w_shift >= {1'b0, r_mag_b});
    // Remainder after a successful subtract is below the divisor, so XLEN bits suffice.
    w_sub      = w_shift[XLEN-1:0] - r_mag_b;
    w_prod_fix = r_neg_q ? -r_acc : r_acc;
    w_quo_fix  = r_neg_q ? -r_quo : r_quo;
    w_rem_fix  = r_neg_r ? -r_rem : r_rem;
    case (r_op)
      3'b000:                 w_fix_result = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_result = w_quo_fix;
      default:                w_fix_result = w_rem_fix;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state; kill overrides everything, including a same-cycle start.
  always_comb begin
    w_state_next = r_state;
    if (bus.kill) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle: if (w_accept) w_state_next = w_special ? StDone : StCalc;
        StCalc: if (r_cnt == LastCnt) w_state_next = StFix;
        StFix:  w_state_next = StDone;
        StDone: begin
          if (w_accept) begin
            w_state_next = w_special ? StDone : StCalc;
          end else begin
            w_state_next = StIdle;
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    bus.busy   = (r_state == StCalc) || (r_state == StFix);
    bus.done   = (r_state == StDone);
    bus.result = r_result;
  end

  // Datapath: capture at accept, iterate in CALC, register the result in FIX.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_op     <= '0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op    <= bus.op;
      r_mag_a <= w_mag_a;
      r_mag_b <= w_mag_b;
      r_neg_q <= w_sign_a ^ w_sign_b;
      r_neg_r <= w_sign_a;
      r_cnt   <= '0;
      r_acc   <= {{XLEN{1'b0}}, w_mag_b};
      r_rem   <= '0;
      r_quo   <= w_mag_a;
      if (w_special) begin
        r_result <= w_special_result;
      end
    end else if (!bus.kill && (r_state == StCalc)) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_acc_next;
      r_rem <= w_ge ? w_sub : w_shift[XLEN-1:0];
      r_quo <= {r_quo[XLEN-2:0], w_ge};
    end else if (!bus.kill && (r_state == StFix)) begin
      r_result <= w_fix_result;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected result and done cycle,
// an independent monitor pops and compares on every done pulse.
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(32)) bus_if ();

  muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic [31:0] res;
    int unsigned at;
    string       name;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          special;
    string       name;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [31:0] last_result = '0;
  vec_t        vecs[15];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus_if.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
      end else begin
        mon_e = sb.pop_front();
        check32({mon_e.name, "_result"}, bus_if.result, mon_e.res);
        check_int({mon_e.name, "_done_cycle"}, cyc, mon_e.at);
        check32({mon_e.name, "_busy_at_done"}, {31'b0, bus_if.busy}, 32'd0);
        last_result = mon_e.res;
      end
    end
  end

  // Caller positions at a negedge; accept happens on the following posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input bit special, input bit expect_resp,
                       input string name, output int unsigned c0);
    bus_if.start = 1'b1;
    bus_if.op    = op;
    bus_if.rs1   = a;
    bus_if.rs2   = b;
    @(posedge clk);
    #1;
    c0 = cyc;
    if (expect_resp) sb.push_back('{res: res, at: c0 + (special ? 0 : 33), name: name});
    bus_if.start = 1'b0;
    // Scramble operands: the DUT must have captured them already.
    bus_if.op    = 3'($urandom_range(0, 7));
    bus_if.rs1   = $urandom;
    bus_if.rs2   = $urandom;
  endtask

  // Returns at the negedge where done is seen; optionally checks busy stayed high before it.
  task automatic wait_done(input string name, input bit chk_busy);
    bit seen    = 1'b0;
    bit busy_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus_if.busy !== 1'b1) busy_ok = 1'b0;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done in 40 cycles, expected done", name);
    end
    if (chk_busy) check32({name, "_busy_until_done"}, {31'b0, busy_ok}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned c0;
    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, "mul_7_m3"};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, "mulh_min_min"};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "mulhu_max"};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "mulhsu_m1_max"};
    vecs[4]  = '{3'b001, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 1'b0, "mulh_m7_3"};
    vecs[5]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, "div_m7_2"};
    vecs[6]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, "rem_m7_2"};
    vecs[7]  = '{3'b101, 32'd100,      32'd7,        32'd14,       1'b0, "divu_100_7"};
    vecs[8]  = '{3'b111, 32'd100,      32'd7,        32'd2,        1'b0, "remu_100_7"};
    vecs[9]  = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, "div_7_m2"};
    vecs[10] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0, "rem_7_m2"};
    vecs[11] = '{3'b101, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1'b1, "divu_by0"};
    vecs[12] = '{3'b110, 32'h00001234, 32'd0,        32'h00001234, 1'b1, "rem_by0"};
    vecs[13] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div_ovf"};
    vecs[14] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1, "rem_ovf"};

    bus_if.start = 1'b0;
    bus_if.kill  = 1'b0;
    bus_if.op    = '0;
    bus_if.rs1   = '0;
    bus_if.rs2   = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check32("reset_busy",   {31'b0, bus_if.busy}, 32'd0);
    check32("reset_done",   {31'b0, bus_if.done}, 32'd0);
    check32("reset_result", bus_if.result,        32'd0);
    rst = 1'b1;

    // Directed vectors, including special cases.
    foreach (vecs[i]) begin
      @(negedge clk);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].special, 1'b1,
            vecs[i].name, c0);
      wait_done(vecs[i].name, !vecs[i].special);
    end

    // Back-to-back: start in the DONE cycle.
    @(negedge clk);
    issue(3'b000, 32'd5, 32'd6, 32'd30, 1'b0, 1'b1, "b2b_first", c0);
    wait_done("b2b_first", 1'b1);
    issue(3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1, "b2b_second", c0);
    wait_done("b2b_second", 1'b1);

    // Start while busy is ignored.
    @(negedge clk);
    issue(3'b011, 32'h00010000, 32'h00010000, 32'd1, 1'b0, 1'b1, "busy_start", c0);
    repeat (5) @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op    = 3'b100;
    bus_if.rs1   = 32'd1;
    bus_if.rs2   = 32'd1;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_done("busy_start", 1'b1);

    // Kill mid-divide at T+10, then MUL 3x4.
    @(negedge clk);
    issue(3'b100, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0, "killed_div", c0);
    repeat (10) @(negedge clk);
    bus_if.kill = 1'b1;
    @(negedge clk);
    bus_if.kill = 1'b0;
    check32("kill_busy",   {31'b0, bus_if.busy}, 32'd0);
    check32("kill_done",   {31'b0, bus_if.done}, 32'd0);
    check32("kill_result", bus_if.result,        last_result);
    issue(3'b000, 32'd3, 32'd4, 32'd12, 1'b0, 1'b1, "mul_after_kill", c0);
    wait_done("mul_after_kill", 1'b1);

    // Kill and start together: not accepted.
    @(negedge clk);
    bus_if.kill  = 1'b1;
    bus_if.start = 1'b1;
    bus_if.op    = 3'b000;
    bus_if.rs1   = 32'd9;
    bus_if.rs2   = 32'd9;
    @(negedge clk);
    bus_if.kill  = 1'b0;
    bus_if.start = 1'b0;
    check32("kill_start_busy", {31'b0, bus_if.busy}, 32'd0);
    repeat (40) @(negedge clk);

    // Synchronous reset mid-multiply at T+5.
    @(negedge clk);
    issue(3'b000, 32'd11, 32'd13, 32'd0, 1'b0, 1'b0, "reset_mul", c0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check32("midrst_busy",   {31'b0, bus_if.busy}, 32'd0);
    check32("midrst_done",   {31'b0, bus_if.done}, 32'd0);
    check32("midrst_result", bus_if.result,        32'd0);
    rst = 1'b1;
    last_result = '0;
    repeat (40) @(negedge clk);

    check_int("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer attached beside the execute-stage ALU.
- The decoder raises start for M-extension instructions. The block holds busy so the core stalls PC and writeback, runs a 1-bit-per-cycle shift-add or restoring-divide loop, then pulses done with the 32-bit result for rd.
- Handles all RISC-V sign, divide-by-zero and overflow rules internally.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- start  input  1  request; sampled only when state is IDLE or DONE
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  input  32  operand A (dividend / multiplicand)
- rs2  input  32  operand B (divisor / multiplier)
- kill  input  1  flush; abandons any operation in flight
- busy  output  1  high in CALC and FIX; core stalls while high
- done  output  1  one-cycle pulse; result valid in that cycle
- result  output  32  registered result; held until the next done

Behaviour:
- Reset (rst==0 at a clock edge): state=IDLE; busy=0, done=0, result=0; counter and internal registers cleared. Applies mid-operation; no done is produced for the aborted op.
- States:
  - IDLE: waits for start.
  - CALC: iteration loop.
  - FIX: sign correction and result select.
  - DONE: done=1, busy=0.
- Accept (IDLE or DONE, start=1, kill=0) at edge T:
  - Latch op.
  - Latch magnitudes |rs1|, |rs2| per signedness:
    - MUL/MULH/DIV/REM: both signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - MULHU/DIVU/REMU: both unsigned.
  - Latch neg_q = sA^sB and neg_r = sA.
  - Clear counter; go to CALC.
- Special cases detected at accept; bypass CALC/FIX and go straight to DONE (done in cycle T+1):
  - Divide by zero (op[2]=1, rs2==0): DIV/DIVU result=0xFFFFFFFF; REM/REMU result=rs1.
  - Signed overflow (DIV/REM, rs1==0x80000000, rs2==0xFFFFFFFF): DIV result=0x80000000; REM result=0.
- CALC:
  - Exactly 32 cycles (T+1..T+32), counter 0..31.
  - Multiply: 64-bit accumulator, add magnitude-A when the multiplier LSB is 1, shift right 1.
  - Divide: restoring step on a 33-bit partial remainder, one quotient bit per cycle, MSB first.
  - Counter==31 → FIX.
- FIX (T+33):
  - Negate the 64-bit product if neg_q; negate the quotient if neg_q; negate the remainder if neg_r.
  - Select the low word for MUL, the high word for MULH/MULHSU/MULHU, the quotient for DIV/DIVU, the remainder for REM/REMU.
  - Register into result; → DONE.
- DONE (T+34 for normal ops):
  - done=1 for exactly one cycle.
  - start=1 here is accepted as a new op (back-to-back); otherwise → IDLE.
- Latency: normal ops have done at T+34. Special cases have done at T+1.
- start while busy=1 is ignored; no queueing.
- kill=1 in any state:
  - → IDLE next edge; busy=0 and done=0 from then on.
  - result keeps its previous value.
  - kill with start in the same cycle: kill wins and the op is not accepted.
- Operands are captured at accept; later changes to rs1/rs2/op have no effect.
- Arithmetic is two's complement mod 2^32 on output; negation of 0x80000000 magnitude is handled via the 33-bit/64-bit internal width.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), start at T → busy high T+1..T+33; done at T+34 with result=0xFFFFFFEB; busy=0 in that cycle.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2. All done at T+34.
- DIVU 0x1234/0 → 0xFFFFFFFF at T+1. REM 0x1234/0 → 0x1234 at T+1. DIV 0x80000000/0xFFFFFFFF → 0x80000000 at T+1. REM same operands → 0 at T+1.
- kill at T+10 of a DIV → busy=0 at T+11, no done pulse, result unchanged. A new MUL 3×4 started at T+12 → done at T+46 with result 12.
- rst=0 at T+5 mid-MUL → done=0, busy=0, result=0 after that edge. start during busy is ignored. start in the DONE cycle → next done exactly 34 cycles later.
